serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. It sequences a single one-bit `full_subtractor` cell over `WIDTH` clock cycles, LSB first, to compute `a_in - b_in - borrow_in`, with a registered borrow between bits. The result comes back through a start/busy/done handshake. It sits between a requester issuing subtract operations and the one-bit subtractor datapath, trading latency for area.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 15 +
 rtl/serial_subtractor_ctrl_if.sv | 25 ++
 rtl/serial_subtractor_ctrl_full_subtractor.sv | 13 +
 rtl/serial_subtractor_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types for the bit-serial subtractor controller: FSM state type and
// its encoding constants.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result handshake between a requester and the bit-serial subtractor.
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;

  modport master (
    output start, a_in, b_in, borrow_in,
    input  busy, done, diff_out, borrow_out
  );

  modport slave (
    input  start, a_in, b_in, borrow_in,
    output busy, done, diff_out, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_ctrl_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - c, borrow set when that underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c;
  assign borrow = (~a & b) | (~a & c) | (b & c);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor cell sequenced LSB first,
// with a registered borrow between bits and a start/busy/done handshake.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_subtractor_ctrl_if.slave  sub
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state_r;
  sub_state_t       state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_out_r;
  logic             cell_diff_s;
  logic             cell_borrow_s;
  logic             last_s;
  logic             busy_s;
  logic             done_s;

  full_subtractor u_cell (
    .a      (a_sh_r[0]),
    .b      (b_sh_r[0]),
    .c      (borrow_r),
    .diff   (cell_diff_s),
    .borrow (cell_borrow_s)
  );

  assign last_s = (cnt_r == CNT_LAST);

  // A single-bit result has nothing to shift down, so it is just the cell output.
  if (WIDTH == 1) begin : g_res_one
    assign res_nxt_s = cell_diff_s;
  end else begin : g_res_multi
    assign res_nxt_s = {cell_diff_s, res_r[WIDTH-1:1]};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sub.start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode from the registered state
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      RUN:     busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand shifters, borrow chain, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r       <= '0;
      b_sh_r       <= '0;
      res_r        <= '0;
      borrow_r     <= 1'b0;
      cnt_r        <= '0;
      diff_r       <= '0;
      borrow_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sub.start) begin
            a_sh_r   <= sub.a_in;
            b_sh_r   <= sub.b_in;
            borrow_r <= sub.borrow_in;
            cnt_r    <= '0;
            res_r    <= '0;
          end
        end
        RUN: begin
          res_r    <= res_nxt_s;
          a_sh_r   <= a_sh_r >> 1'b1;
          b_sh_r   <= b_sh_r >> 1'b1;
          borrow_r <= cell_borrow_s;
          cnt_r    <= cnt_r + CNT_ONE;
          // Published outputs only move on completion and hold through later runs.
          if (last_s) begin
            diff_r       <= res_nxt_s;
            borrow_out_r <= cell_borrow_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign sub.busy       = busy_s;
  assign sub.done       = done_s;
  assign sub.diff_out   = diff_r;
  assign sub.borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=1 with a result scoreboard.
module tb_serial_subtractor_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(8)) if8 ();
  serial_subtractor_ctrl_if #(.WIDTH(1)) if1 ();

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (if8.slave)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (if1.slave)
  );

  int         errors = 0;
  int         checks = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] e8;
  logic [1:0] e1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {borrow, diff} from plain wide unsigned subtraction.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'd0, bin};
  endfunction

  function automatic logic [1:0] model1(input logic a, input logic b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {1'b0, bin};
  endfunction

  // Result scoreboards: every done pops and checks one expected result.
  always @(negedge clk) begin
    if (if8.done === 1'b1) begin
      chk("done8_pending", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("diff8", 32'(if8.diff_out), 32'(e8[7:0]));
        chk("borrow8", 32'(if8.borrow_out), 32'(e8[8]));
      end
    end
    if (if1.done === 1'b1) begin
      chk("done1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("diff1", 32'(if1.diff_out), 32'(e1[0]));
        chk("borrow1", 32'(if1.borrow_out), 32'(e1[1]));
      end
    end
  end

  // One WIDTH=8 operation; optional start pulses during RUN and DONE with other operands.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit inject);
    if8.start     = 1'b1;
    if8.a_in      = a;
    if8.b_in      = b;
    if8.borrow_in = bin;
    q8.push_back(model8(a, b, bin));
    @(posedge clk); #1;
    if8.start     = 1'b0;
    if8.a_in      = ~a;
    if8.b_in      = b ^ 8'h5A;
    if8.borrow_in = ~bin;
    for (int i = 0; i < 8; i++) begin
      chk("busy8_run", 32'(if8.busy), 32'd1);
      chk("done8_run", 32'(if8.done), 32'd0);
      if (inject && i == 3) begin
        if8.start = 1'b1;
        if8.a_in  = 8'h11;
        if8.b_in  = 8'hEE;
      end else begin
        if8.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("busy8_done", 32'(if8.busy), 32'd0);
    chk("done8_at_w", 32'(if8.done), 32'd1);
    if (inject) if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    chk("done8_pulse", 32'(if8.done), 32'd0);
    chk("busy8_idle", 32'(if8.busy), 32'd0);
  endtask

  initial begin
    if8.start = 1'b0; if8.a_in = 8'd0; if8.b_in = 8'd0; if8.borrow_in = 1'b0;
    if1.start = 1'b0; if1.a_in = 1'b0; if1.b_in = 1'b0; if1.borrow_in = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", 32'(if8.busy), 32'd0);
    chk("rst_done8", 32'(if8.done), 32'd0);
    chk("rst_diff8", 32'(if8.diff_out), 32'd0);
    chk("rst_borrow8", 32'(if8.borrow_out), 32'd0);
    chk("rst_busy1", 32'(if1.busy), 32'd0);
    chk("rst_diff1", 32'(if1.diff_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8(8'd200, 8'd55, 1'b0, 1'b0);
    op8(8'd5, 8'd10, 1'b0, 1'b0);
    op8(8'd0, 8'd0, 1'b1, 1'b0);
    op8(8'd77, 8'd30, 1'b0, 1'b1);

    // Reset in the middle of an operation: no done may follow.
    if8.start = 1'b1; if8.a_in = 8'd9; if8.b_in = 8'd3; if8.borrow_in = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy8_before_rst", 32'(if8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy8", 32'(if8.busy), 32'd0);
    chk("midrst_done8", 32'(if8.done), 32'd0);
    chk("midrst_diff8", 32'(if8.diff_out), 32'd0);
    chk("midrst_borrow8", 32'(if8.borrow_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("postrst_idle8", 32'(if8.busy), 32'd0);
    op8(8'd100, 8'd1, 1'b1, 1'b0);

    // start held high: back-to-back operations every 10 cycles.
    if8.start = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if8.a_in      = 8'($urandom_range(255, 0));
      if8.b_in      = 8'($urandom_range(255, 0));
      if8.borrow_in = 1'($urandom_range(1, 0));
      q8.push_back(model8(if8.a_in, if8.b_in, if8.borrow_in));
      @(posedge clk); #1;
      chk("bb_busy8", 32'(if8.busy), 32'd1);
      repeat (7) @(posedge clk);
      #1;
      chk("bb_nodone8", 32'(if8.done), 32'd0);
      @(posedge clk); #1;
      chk("bb_done8", 32'(if8.done), 32'd1);
      @(posedge clk); #1;
      chk("bb_gap8", 32'(if8.busy | if8.done), 32'd0);
    end
    if8.start = 1'b0;

    // WIDTH=1: exhaustive full-subtractor truth table.
    for (int c = 0; c < 8; c++) begin
      if1.start     = 1'b1;
      if1.a_in      = 1'(c >> 2);
      if1.b_in      = 1'(c >> 1);
      if1.borrow_in = 1'(c);
      q1.push_back(model1(if1.a_in, if1.b_in, if1.borrow_in));
      @(posedge clk); #1;
      if1.start = 1'b0;
      chk("w1_busy", 32'(if1.busy), 32'd1);
      chk("w1_nodone", 32'(if1.done), 32'd0);
      @(posedge clk); #1;
      chk("w1_done", 32'(if1.done), 32'd1);
      chk("w1_busy_off", 32'(if1.busy), 32'd0);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
